// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode/funct constants, instruction field
// positions and the fetch-stage state encoding.
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD   = 6'b100000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_field_split.sv
// Purely combinational split of a 32-bit instruction word into its fields.
module instr_field_split
    import isa_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm
);

    // Slice the word at the fixed ISA field boundaries
    always_comb begin
        opcode = instr[OPCODE_MSB:OPCODE_LSB];
        rs     = instr[RS_MSB:RS_LSB];
        rt     = instr[RT_MSB:RT_LSB];
        rd     = instr[RD_MSB:RD_LSB];
        funct  = instr[FUNCT_MSB:FUNCT_LSB];
        imm    = instr[IMM_MSB:IMM_LSB];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, runs the imem req/ack
// handshake, holds decoded fields under backpressure, handles redirects
// (including squashing an in-flight fetch) and stops on HALT.
module instr_fetch_unit
    import isa_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]       HALT_OP  = OP_HALT,
    parameter int               CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic              flush, flush_next;
    logic [ADDR_W-1:0] flush_addr, flush_addr_next;
    logic [31:0]       instr_word, instr_next;
    logic [ADDR_W-1:0] pc_out_r, pc_out_next;
    logic [CNT_W-1:0]  count, count_next;

    // The presented fields always come straight from the held instruction word
    instr_field_split u_split (
        .instr  (instr_word),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .funct  (funct),
        .imm    (imm)
    );

    assign pc_out      = pc_out_r;
    assign instr_count = count;

    // Next-state and output decode; a redirect always wins over ack/ready.
    // While flushing, the request keeps the squashed address (flush_addr)
    // so the memory sees a stable address until its ack arrives.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        flush_next      = flush;
        flush_addr_next = flush_addr;
        instr_next      = instr_word;
        pc_out_next     = pc_out_r;
        count_next      = count;
        imem_req        = 1'b0;
        imem_addr       = '0;
        dec_valid       = 1'b0;
        halted          = 1'b0;

        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end
            end

            ST_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = flush ? flush_addr : pc;
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                    if (imem_ack) begin
                        flush_next = 1'b0;
                    end else begin
                        flush_next = 1'b1;
                        if (!flush) begin
                            flush_addr_next = pc;
                        end
                    end
                end else if (imem_ack) begin
                    if (flush) begin
                        flush_next = 1'b0;
                    end else begin
                        instr_next  = imem_rdata;
                        pc_out_next = pc;
                        pc_next     = pc + ADDR_W'(4);
                        state_next  = ST_VALID;
                    end
                end
            end

            ST_VALID: begin
                dec_valid = 1'b1;
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = ST_FETCH;
                end else if (dec_ready) begin
                    count_next = count + CNT_W'(1);
                    state_next = (opcode == HALT_OP) ? ST_HALT : ST_FETCH;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = ST_FETCH;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            flush      <= 1'b0;
            flush_addr <= '0;
            instr_word <= '0;
            pc_out_r   <= '0;
            count      <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            flush      <= flush_next;
            flush_addr <= flush_addr_next;
            instr_word <= instr_next;
            pc_out_r   <= pc_out_next;
            count      <= count_next;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end stage that fetches 32-bit instruction words from instruction memory and presents the decoded fields (opcode, funct, register indices, immediate) to controlunit and the register file. It owns the program counter, handles variable memory latency through a req/ack handshake, and stalls under downstream backpressure. It accepts PC redirects from the execute stage and halts on the HALT opcode.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_OP, 6'b111111, opcode that stops fetching once accepted downstream
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request; held until imem_ack
imem_addr  out  ADDR_W  fetch address; stable while imem_req=1
imem_ack  in  1  read data valid this cycle
imem_rdata  in  32  instruction word
dec_valid  out  1  decoded fields valid
dec_ready  in  1  downstream accepts fields this cycle
opcode  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
funct  out  6  instr[5:0]
imm  out  16  instr[15:0]
pc_out  out  ADDR_W  address of presented instruction
redirect_valid  in  1  load new PC
redirect_pc  in  ADDR_W  redirect target, word aligned
halted  out  1  HALT state indicator
instr_count  out  CNT_W  number of instructions accepted downstream

Behaviour:
- One clock, clk. Reset is synchronous, active-low on rst_n. Sampled only at the rising edge; it overrides all other inputs, including mid-handshake.
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0, dec_valid=0, all field outputs 0, pc_out=0, halted=0, instr_count=0, flush=0.
- States: IDLE, FETCH, VALID, HALT.
- IDLE: next cycle goes to FETCH. No request is issued in IDLE.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack with flush=0: register the fields from imem_rdata, set pc_out=pc and pc<=pc+4, then go to VALID.
  - Fetch latency is at least 1 cycle after the ack (registered outputs).
- VALID: dec_valid=1 and the fields are held stable.
  - On dec_ready: instr_count<=instr_count+1, which wraps at 2^CNT_W.
  - If opcode==HALT_OP, go to HALT; otherwise go to FETCH.
  - Without dec_ready, stay in VALID.
- HALT: imem_req=0, dec_valid=0, halted=1. Remain in HALT until redirect_valid.
- Redirect has priority over dec_ready and imem_ack.
  - FETCH with no ack this cycle: the outstanding request must complete with its address unchanged. Set flush=1 and pc<=redirect_pc. The next ack is dropped and clears flush, then a new request starts at the new pc.
  - FETCH with ack in the same cycle: drop the data, pc<=redirect_pc, stay in FETCH.
  - VALID: dec_valid drops next cycle, the instruction is not counted, pc<=redirect_pc, go to FETCH.
  - HALT: pc<=redirect_pc, halted=0, go to FETCH.
  - IDLE: pc<=redirect_pc.
- PC arithmetic is modulo 2^ADDR_W; 0xFFFF_FFFC+4 wraps to 0.
- imem_req never deasserts before imem_ack.

Decomposition:
- Shared package, isa_pkg: opcode constants (OP_RTYPE=6'b000001, OP_LW=6'b000100, OP_SW=6'b000010, OP_HALT=6'b111111), funct constants (FN_ADD=6'b100000), field bit positions, and the fetch-state encoding. controlunit imports the same package.
- Natural sub-module: instr_field_split, a combinational split of the 32-bit word into fields, reused by the bench checker.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while imem_ack=1 -> all outputs 0, imem_req=0. First request is at imem_addr=0 two cycles after release.
- ADD fetch: imem_rdata=32'h0422_1820, ack after 2 cycles, dec_ready=1 -> opcode=000001, rs=1, rt=2, rd=3, funct=100000, pc_out=0. Next imem_addr=4, instr_count=1.
- Backpressure: LW word 32'h1041_0008, dec_ready=0 for 5 cycles -> dec_valid held, imm=16'h0008, rt=1, no new imem_req. Advances on dec_ready=1.
- Redirect during outstanding request: redirect_pc=0x40 while waiting for ack -> imem_addr stays at the old pc until ack. That data is discarded (dec_valid stays 0), then the next request is at 0x40.
- Halt: 32'hFC00_0000 accepted -> halted=1, imem_req=0 indefinitely. redirect_valid with redirect_pc=0x100 -> halted=0, next request at 0x100.
- Reset mid-VALID: rst_n=0 while dec_valid=1 -> next cycle dec_valid=0, instr_count=0, pc=RESET_PC.
